// File: rtl/icetap_jtag_pkg.sv
// Shared TAP state encoding and instruction opcodes for the icetap JTAG port.
// ICETAP_JTAG_IDCODE_EN selects IDCODE as the reset instruction.
package icetap_jtag_pkg;

    // IEEE 1149.1 reference encoding
    typedef enum logic [3:0] {
        TAP_EXIT2_DR  = 4'h0,
        TAP_EXIT1_DR  = 4'h1,
        TAP_SHIFT_DR  = 4'h2,
        TAP_PAUSE_DR  = 4'h3,
        TAP_SEL_IR    = 4'h4,
        TAP_UPDATE_DR = 4'h5,
        TAP_CAP_DR    = 4'h6,
        TAP_SEL_DR    = 4'h7,
        TAP_EXIT2_IR  = 4'h8,
        TAP_EXIT1_IR  = 4'h9,
        TAP_SHIFT_IR  = 4'hA,
        TAP_PAUSE_IR  = 4'hB,
        TAP_RTI       = 4'hC,
        TAP_UPDATE_IR = 4'hD,
        TAP_CAP_IR    = 4'hE,
        TAP_TLR       = 4'hF
    } tap_state_e;

    localparam logic [3:0] INSTR_EXTEST = 4'b0000;
    localparam logic [3:0] INSTR_SCAN_N = 4'b0010;
    localparam logic [3:0] INSTR_IDCODE = 4'b1110;
    localparam logic [3:0] INSTR_BYPASS = 4'b1111;

`ifdef ICETAP_JTAG_IDCODE_EN
    localparam logic [3:0] INSTR_RESET = INSTR_IDCODE;
`else
    localparam logic [3:0] INSTR_RESET = INSTR_BYPASS;
`endif

endpackage

// File: rtl/icetap_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; next state depends only on tms.
//
//   state     | meaning
//   ----------+------------------------------------------
//   TLR       | test-logic-reset, instruction forced
//   RTI       | run-test/idle
//   SEL_DR    | select DR scan
//   CAP_DR    | capture into selected data register
//   SHIFT_DR  | shift selected data register
//   EXIT1_DR  | leave DR shift
//   PAUSE_DR  | hold DR shift
//   EXIT2_DR  | leave DR pause
//   UPDATE_DR | DR scan complete
//   SEL_IR    | select IR scan
//   CAP_IR    | load IR shifter with ...0001
//   SHIFT_IR  | shift IR shifter
//   EXIT1_IR  | leave IR shift
//   PAUSE_IR  | hold IR shift
//   EXIT2_IR  | leave IR pause
//   UPDATE_IR | IR shifter copied to instruction
module icetap_tap_fsm
    import icetap_jtag_pkg::*;
(
    input  logic       tck,
    input  logic       reset_,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:       state_d = tms ? TAP_TLR       : TAP_RTI;
            TAP_RTI:       state_d = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_DR:    state_d = tms ? TAP_SEL_IR    : TAP_CAP_DR;
            TAP_CAP_DR:    state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:  state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:  state_d = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:  state_d = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:  state_d = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR: state_d = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_IR:    state_d = tms ? TAP_TLR       : TAP_CAP_IR;
            TAP_CAP_IR:    state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:  state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:  state_d = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:  state_d = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:  state_d = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR: state_d = tms ? TAP_SEL_DR    : TAP_RTI;
            default:       state_d = TAP_TLR;
        endcase
    end

    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) state_q <= TAP_TLR;
        else         state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/icetap_jtag_tap.sv
// JTAG TAP for the icetap block: IR, BYPASS and optional IDCODE register.
// Define ICETAP_JTAG_IDCODE_EN to add the 32-bit ID register and make IDCODE the reset instruction.
module icetap_jtag_tap
    import icetap_jtag_pkg::*;
#(
    parameter int unsigned IR_BITS      = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic tck,
    input  logic reset_,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_en,
    input  logic icetap_tdo,
    output logic test_logic_reset,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic scan_n_ir,
    output logic extest_ir
);

    localparam logic [IR_BITS-1:0] IR_RESET  = IR_BITS'(INSTR_RESET);
    localparam logic [IR_BITS-1:0] IR_EXTEST = IR_BITS'(INSTR_EXTEST);
    localparam logic [IR_BITS-1:0] IR_SCAN_N = IR_BITS'(INSTR_SCAN_N);

    tap_state_e state;

    logic [IR_BITS-1:0] ir_shift_q, ir_shift_d;
    logic [IR_BITS-1:0] ir_q, ir_d;
    logic [IR_BITS-1:0] ir_cur;
    logic               bypass_q, bypass_d;
    logic               sel_icetap;

    icetap_tap_fsm u_fsm (
        .tck    (tck),
        .reset_ (reset_),
        .tms    (tms),
        .state  (state)
    );

    // Masking in TLR makes the reset instruction visible on the same edge TLR is entered
    assign ir_cur     = (state == TAP_TLR) ? IR_RESET : ir_q;
    assign sel_icetap = (ir_cur == IR_SCAN_N) || (ir_cur == IR_EXTEST);

`ifdef ICETAP_JTAG_IDCODE_EN
    localparam logic [IR_BITS-1:0] IR_IDCODE = IR_BITS'(INSTR_IDCODE);

    logic [31:0] idcode_q, idcode_d;
    logic        sel_idcode;

    assign sel_idcode = (ir_cur == IR_IDCODE);

    always_comb begin
        idcode_d = idcode_q;
        if (sel_idcode && state == TAP_CAP_DR)
            idcode_d = IDCODE_VALUE;
        else if (sel_idcode && state == TAP_SHIFT_DR)
            idcode_d = {tdi, idcode_q[31:1]};
    end

    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) idcode_q <= '0;
        else         idcode_q <= idcode_d;
    end
`endif

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        bypass_d   = bypass_q;
        case (state)
            TAP_TLR:       ir_d       = IR_RESET;
            TAP_CAP_IR:    ir_shift_d = IR_BITS'(1);
            TAP_SHIFT_IR:  ir_shift_d = (ir_shift_q >> 1) | (IR_BITS'(tdi) << (IR_BITS - 1));
            TAP_UPDATE_IR: ir_d       = ir_shift_q;
            TAP_CAP_DR:    bypass_d   = 1'b0;
            TAP_SHIFT_DR:  bypass_d   = tdi;
            default: ;
        endcase
    end

    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            ir_shift_q <= '0;
            ir_q       <= IR_RESET;
            bypass_q   <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_q       <= ir_d;
            bypass_q   <= bypass_d;
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state == TAP_SHIFT_IR) begin
            tdo = ir_shift_q[0];
        end else if (state == TAP_SHIFT_DR) begin
            if (sel_icetap)
                tdo = icetap_tdo;
`ifdef ICETAP_JTAG_IDCODE_EN
            else if (sel_idcode)
                tdo = idcode_q[0];
`endif
            else
                tdo = bypass_q;
        end
    end

    assign tdo_en           = (state == TAP_SHIFT_DR) || (state == TAP_SHIFT_IR);
    assign test_logic_reset = (state == TAP_TLR);
    assign capture_dr       = (state == TAP_CAP_DR);
    assign shift_dr         = (state == TAP_SHIFT_DR);
    assign update_dr        = (state == TAP_UPDATE_DR);
    assign scan_n_ir        = (ir_cur == IR_SCAN_N);
    assign extest_ir        = (ir_cur == IR_EXTEST);

endmodule

// File: tb/tb_icetap_jtag_tap.sv
// Directed bench for icetap_jtag_tap; honours ICETAP_JTAG_IDCODE_EN when defined.
module tb_icetap_jtag_tap;

    logic tck = 1'b0;
    logic reset_;
    logic tms;
    logic tdi;
    logic icetap_tdo;
    logic tdo;
    logic tdo_en;
    logic test_logic_reset;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic scan_n_ir;
    logic extest_ir;

    int checks   = 0;
    int failures = 0;

    icetap_jtag_tap dut (
        .tck              (tck),
        .reset_           (reset_),
        .tms              (tms),
        .tdi              (tdi),
        .tdo              (tdo),
        .tdo_en           (tdo_en),
        .icetap_tdo       (icetap_tdo),
        .test_logic_reset (test_logic_reset),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .scan_n_ir        (scan_n_ir),
        .extest_ir        (extest_ir)
    );

    always #5 tck = ~tck;

    // One tck: drive inputs, wait for the rising edge, settle 1 time unit past it
    task automatic step(input logic t_tms, input logic t_tdi);
        tms = t_tms;
        tdi = t_tdi;
        @(posedge tck);
        #1;
    endtask

    task automatic go_rti();
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic rti_to_shift_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // RTI -> IR scan of code -> RTI
    task automatic load_ir(input logic [3:0] code);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i == 3, code[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        reset_     = 1'b0;
        tms        = 1'b1;
        tdi        = 1'b0;
        icetap_tdo = 1'b1;
        #22;
        obs = {test_logic_reset, capture_dr, shift_dr, update_dr, tdo, tdo_en, scan_n_ir, extest_ir};
        checks++;
        if (obs !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 8'b1000_0000);
        end
        reset_ = 1'b1;
        @(posedge tck);
        #1;
        icetap_tdo = 1'b0;
    endtask

    task automatic test_tlr_from_all();
        logic [7:0] path [16];
        int         plen [16];
        logic [4:0] flags [16];
        logic [7:0] p;
        logic [4:0] obs;
        path[0]  = 8'b0000_0111; plen[0]  = 3; flags[0]  = 5'b10000;
        path[1]  = 8'b0000_0000; plen[1]  = 0; flags[1]  = 5'b00000;
        path[2]  = 8'b0000_0001; plen[2]  = 1; flags[2]  = 5'b00000;
        path[3]  = 8'b0000_0001; plen[3]  = 2; flags[3]  = 5'b01000;
        path[4]  = 8'b0000_0001; plen[4]  = 3; flags[4]  = 5'b00101;
        path[5]  = 8'b0000_0101; plen[5]  = 3; flags[5]  = 5'b00000;
        path[6]  = 8'b0000_0101; plen[6]  = 4; flags[6]  = 5'b00000;
        path[7]  = 8'b0001_0101; plen[7]  = 5; flags[7]  = 5'b00000;
        path[8]  = 8'b0000_1101; plen[8]  = 4; flags[8]  = 5'b00010;
        path[9]  = 8'b0000_0011; plen[9]  = 2; flags[9]  = 5'b00000;
        path[10] = 8'b0000_0011; plen[10] = 3; flags[10] = 5'b00000;
        path[11] = 8'b0000_0011; plen[11] = 4; flags[11] = 5'b00001;
        path[12] = 8'b0000_1011; plen[12] = 4; flags[12] = 5'b00000;
        path[13] = 8'b0000_1011; plen[13] = 5; flags[13] = 5'b00000;
        path[14] = 8'b0010_1011; plen[14] = 6; flags[14] = 5'b00000;
        path[15] = 8'b0001_1011; plen[15] = 5; flags[15] = 5'b00000;
        for (int s = 0; s < 16; s++) begin
            go_rti();
            load_ir(4'b0010);
            p = path[s];
            for (int i = 0; i < plen[s]; i++) step(p[i], 1'b0);
            obs = {test_logic_reset, capture_dr, shift_dr, update_dr, tdo_en};
            checks++;
            if (obs !== flags[s]) begin
                failures++;
                $display("FAIL walk_state%0d_decode: got %b expected %b", s, obs, flags[s]);
            end
            repeat (5) step(1'b1, 1'b0);
            checks++;
            if (test_logic_reset !== 1'b1 || scan_n_ir !== 1'b0 || extest_ir !== 1'b0) begin
                failures++;
                $display("FAIL tlr_from_state%0d: got tlr=%b scan_n=%b extest=%b expected 1 0 0",
                         s, test_logic_reset, scan_n_ir, extest_ir);
            end
            step(1'b0, 1'b0);
            checks++;
            if (scan_n_ir !== 1'b0 || test_logic_reset !== 1'b0) begin
                failures++;
                $display("FAIL ir_reset_held_state%0d: got scan_n=%b tlr=%b expected 0 0",
                         s, scan_n_ir, test_logic_reset);
            end
        end
    endtask

    task automatic test_ir_scan();
        logic [3:0] code;
        logic [3:0] cap;
        code = 4'b0010;
        cap  = 4'b0001;
        go_rti();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tdo !== cap[i] || tdo_en !== 1'b1) begin
                failures++;
                $display("FAIL ir_shift_bit%0d: got tdo=%b en=%b expected %b 1", i, tdo, tdo_en, cap[i]);
            end
            step(i == 3, code[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (scan_n_ir !== 1'b1 || extest_ir !== 1'b0) begin
            failures++;
            $display("FAIL ir_update_scan_n: got scan_n=%b extest=%b expected 1 0", scan_n_ir, extest_ir);
        end
    endtask

    task automatic test_scan_n_shift();
        logic [7:0] pat;
        pat = 8'b1101_0010;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (capture_dr !== 1'b1 || shift_dr !== 1'b0) begin
            failures++;
            $display("FAIL scan_n_capture: got cap=%b shift=%b expected 1 0", capture_dr, shift_dr);
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            icetap_tdo = pat[i];
            #1;
            checks++;
            if (tdo !== pat[i] || shift_dr !== 1'b1) begin
                failures++;
                $display("FAIL scan_n_pass_bit%0d: got tdo=%b shift=%b expected %b 1", i, tdo, shift_dr, pat[i]);
            end
            step(i == 7, 1'b0);
        end
        icetap_tdo = 1'b1;
        #1;
        checks++;
        if (shift_dr !== 1'b0 || tdo !== 1'b0 || tdo_en !== 1'b0) begin
            failures++;
            $display("FAIL scan_n_exit: got shift=%b tdo=%b en=%b expected 0 0 0", shift_dr, tdo, tdo_en);
        end
        icetap_tdo = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_extest();
        logic [3:0] pat;
        pat = 4'b0110;
        load_ir(4'b0000);
        checks++;
        if (extest_ir !== 1'b1 || scan_n_ir !== 1'b0) begin
            failures++;
            $display("FAIL extest_decode: got extest=%b scan_n=%b expected 1 0", extest_ir, scan_n_ir);
        end
        rti_to_shift_dr();
        for (int i = 0; i < 4; i++) begin
            icetap_tdo = pat[i];
            #1;
            checks++;
            if (tdo !== pat[i]) begin
                failures++;
                $display("FAIL extest_pass_bit%0d: got %b expected %b", i, tdo, pat[i]);
            end
            step(i == 3, 1'b0);
        end
        icetap_tdo = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // Optionally load code, then expect one-tck bypass delay on 10110011
    task automatic test_bypass(input logic do_load, input logic [3:0] code);
        logic [7:0] bits;
        logic       prev;
        logic       b;
        bits = 8'b1011_0011;
        prev = 1'b0;
        if (do_load) load_ir(code);
        checks++;
        if (scan_n_ir !== 1'b0 || extest_ir !== 1'b0) begin
            failures++;
            $display("FAIL bypass_%b_decode: got scan_n=%b extest=%b expected 0 0", code, scan_n_ir, extest_ir);
        end
        rti_to_shift_dr();
        for (int i = 0; i < 8; i++) begin
            b = bits[7 - i];
            checks++;
            if (tdo !== prev) begin
                failures++;
                $display("FAIL bypass_%b_bit%0d: got %b expected %b", code, i, tdo, prev);
            end
            step(i == 7, b);
            prev = b;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

`ifdef ICETAP_JTAG_IDCODE_EN
    task automatic test_idcode();
        logic [31:0] exp_id;
        exp_id = 32'h1000_0001;
        rti_to_shift_dr();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (tdo !== exp_id[i]) begin
                failures++;
                $display("FAIL idcode_bit%0d: got %b expected %b", i, tdo, exp_id[i]);
            end
            step(i == 31, 1'b0);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask
`endif

    task automatic test_reset_mid_shift();
        logic [7:0] obs;
        go_rti();
        load_ir(4'b0010);
        rti_to_shift_dr();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        icetap_tdo = 1'b1;
        #2;
        reset_ = 1'b0;
        #1;
        obs = {test_logic_reset, capture_dr, shift_dr, update_dr, tdo, tdo_en, scan_n_ir, extest_ir};
        checks++;
        if (obs !== 8'b1000_0000) begin
            failures++;
            $display("FAIL mid_shift_reset_outputs: got %b expected %b", obs, 8'b1000_0000);
        end
        reset_     = 1'b1;
        icetap_tdo = 1'b0;
        @(posedge tck);
        #1;
        step(1'b0, 1'b0);
        checks++;
        if (scan_n_ir !== 1'b0 || test_logic_reset !== 1'b0) begin
            failures++;
            $display("FAIL mid_shift_reset_ir: got scan_n=%b tlr=%b expected 0 0", scan_n_ir, test_logic_reset);
        end
`ifdef ICETAP_JTAG_IDCODE_EN
        test_idcode();
`else
        test_bypass(1'b0, 4'b1111);
`endif
    endtask

    initial begin
        test_reset();
        test_tlr_from_all();
        test_ir_scan();
        test_scan_n_shift();
        test_extest();
        test_bypass(1'b1, 4'b1111);
        test_bypass(1'b1, 4'b0101);
`ifdef ICETAP_JTAG_IDCODE_EN
        go_rti();
        test_idcode();
`else
        test_bypass(1'b1, 4'b1110);
`endif
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icetap_jtag_tap.md
ICETAP_JTAG_TAP -- requirements
Module: icetap_jtag_tap

Interface
REQ-001 SHALL have parameter IR_BITS, default 4, instruction register width.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h1000_0001, value captured by IDCODE (bit 0 SHALL be 1).
REQ-003 SHALL have port tck, input, 1, sole clock; all flops rising-edge.
REQ-004 SHALL have port reset_, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tms, input, 1, TAP mode select, sampled on tck rise.
REQ-006 SHALL have port tdi, input, 1, serial data in.
REQ-007 SHALL have port tdo, output, 1, serial data out.
REQ-008 SHALL have port tdo_en, output, 1, high only in Shift-DR or Shift-IR.
REQ-009 SHALL have port icetap_tdo, input, 1, serial return from the icetap register block.
REQ-010 SHALL have ports test_logic_reset, capture_dr, shift_dr, update_dr, each output, 1, high while the TAP is in the matching state.
REQ-011 SHALL have ports scan_n_ir and extest_ir, each output, 1, high while the current instruction is SCAN_N or EXTEST.

Function
REQ-012 SHALL implement the 16-state IEEE 1149.1 TAP FSM, next state a function of current state and tms only.
REQ-013 SHALL register the state; REQ-010 and REQ-008 outputs SHALL decode the registered state (Moore, no tms combinational path).
REQ-014 Instruction codes SHALL be EXTEST=0000, SCAN_N=0010, IDCODE=1110, BYPASS=1111; any other code SHALL behave as BYPASS.
REQ-015 Capture-IR SHALL load the IR shift register with binary ...0001 (LSB first: 1,0,0,...).
REQ-016 Shift-IR SHALL shift tdi into the MSB and present the LSB on tdo.
REQ-017 Update-IR SHALL copy the IR shift register to the instruction register; the instruction SHALL otherwise hold.
REQ-018 BYPASS SHALL use a 1-bit register cleared in Capture-DR; Shift-DR SHALL give exactly one tck of tdi-to-tdo delay.
REQ-019 For SCAN_N and EXTEST, tdo SHALL equal icetap_tdo in Shift-DR; this block SHALL NOT hold those data registers.
REQ-020 tdo SHALL be a combinational mux of the selected register LSB; outside shift states tdo SHALL be 0.
REQ-021 Test-Logic-Reset SHALL force the instruction to the reset instruction (REQ-026), independent of reset_.
REQ-022 Five consecutive tck rises with tms=1 SHALL reach Test-Logic-Reset from any state.

Reset
REQ-023 reset_ low SHALL asynchronously force state to Test-Logic-Reset and the instruction to the reset instruction.
REQ-024 During reset: test_logic_reset=1; capture_dr=shift_dr=update_dr=0; tdo=0; tdo_en=0; scan_n_ir=extest_ir=0; all shift registers 0.
REQ-025 Reset deassertion mid-shift SHALL restart from Test-Logic-Reset; partially shifted data SHALL be discarded.

Configuration
REQ-026 With ICETAP_JTAG_IDCODE_EN defined: IDCODE instruction and 32-bit ID register present, Capture-DR loads IDCODE_VALUE, reset instruction is IDCODE.
REQ-027 Without ICETAP_JTAG_IDCODE_EN: no ID register, code 1110 acts as BYPASS, reset instruction is BYPASS.

Structure
REQ-028 Package icetap_jtag_pkg SHALL hold the TAP state encoding (4-bit enum, 16 values) and the instruction code constants.
REQ-029 The FSM SHALL be sub-module icetap_tap_fsm (ports tck, reset_, tms, state); IR/DR logic stays in icetap_jtag_tap.

Verification
REQ-030 From each of the 16 states, tms=1 for 5 tck -> test_logic_reset=1 and the instruction is the reset instruction.
REQ-031 IR scan shifting in 0010 -> tdo bits 1,0,0,0 during Shift-IR; after Update-IR, scan_n_ir=1 and extest_ir=0.
REQ-032 BYPASS: shift 8 bits 10110011 in Shift-DR -> tdo is 0 followed by the first 7 bits, one tck late.
REQ-033 With ICETAP_JTAG_IDCODE_EN and the default IDCODE_VALUE, DR scan after reset -> 32 tdo bits equal 32'h1000_0001, LSB first.
REQ-034 SCAN_N loaded: Shift-DR with icetap_tdo toggling -> tdo equals icetap_tdo each cycle; shift_dr=1 only in Shift-DR.
REQ-035 reset_ pulsed low during Shift-DR -> outputs take the REQ-024 values immediately and the instruction returns to the reset instruction.
